instruction_fetch: RTL

- Upstream neighbour of the control path.
- Owns the program counter (PC) and fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake.
- Holds the instruction stable for the decoder until the control path pulses `pc_inc`, then advances sequentially or to a branch target.
- Stops permanently on `halt` or on a misaligned target; only reset recovers.

---
 rtl/instruction_fetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid handshake and holds it for the control path until consumed.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP        = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_inc,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic                  instruction_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  fault_q, fault_d;
  logic                  req_q, valid_q, halted_q;

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: state_d = halt ? S_HALTED : S_REQ;
      S_REQ: begin
        // A granted request must still see its response before stopping.
        if (halt)          state_d = imem_gnt ? S_DRAIN : S_HALTED;
        else if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (halt) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (imem_rvalid) state_d = S_HALTED;
      S_HOLD: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (pc_inc) begin
          if (!branch_valid) begin
            pc_d    = pc_q + ADDR_WIDTH'(4);
            state_d = S_REQ;
          end else if (branch_target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALTED;
          end else begin
            pc_d    = branch_target;
            state_d = S_REQ;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_HALTED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      fault_q  <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
      req_q    <= (state_d == S_REQ);
      valid_q  <= (state_d == S_HOLD);
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign imem_req          = req_q;
  assign imem_addr         = pc_q;
  assign pc                = pc_q;
  assign instruction_valid = valid_q;
  assign instruction       = valid_q ? instr_q : NOP;
  assign halted            = halted_q;
  assign fault             = fault_q;

endmodule
